ps2_key_tracker: RTL

- Sits between the PS/2 receiver FIFO (ps2_keyboard) and the display path (ASCII LUT, BCD, seven-segment).
- Pops raw scan-code bytes using the receiver's ready/nextdata_n handshake.
- Decodes make, break (F0) and extended (E0) sequences.
- Outputs the currently held key, a press event pulse and a press counter. Typematic repeats are excluded from the counter, which wraps for two-digit display.

---
 rtl/ps2_key_tracker.sv | 118 +++++++++++
 1 files changed

// File: rtl/ps2_key_tracker.sv
// Scan-code tracker: pops bytes from the PS/2 receiver FIFO, decodes E0/F0
// prefixed sequences and reports the held key, a press pulse and a wrapping press count.
module ps2_key_tracker #(
   parameter int COUNT_MAX = 99,
   parameter int CNT_W     = 8
) (
   input  logic             i_clk,
   input  logic             i_clr_n,
   input  logic [7:0]       i_ps2_data,
   input  logic             i_ps2_ready,
   output logic             o_nextdata_n,
   output logic [7:0]       o_key_code,
   output logic             o_key_ext,
   output logic             o_key_valid,
   output logic             o_key_pressed,
   output logic [CNT_W-1:0] o_press_count
);

   // Handshake: a byte is consumed on an edge where i_ps2_ready=1 and no pop is
   // outstanding; o_nextdata_n is then low for exactly the following cycle.
   typedef enum logic {
      S_IDLE = 1'b0,
      S_HELD = 1'b1
   } state_t;

   localparam logic [7:0] BYTE_EXT = 8'hE0;
   localparam logic [7:0] BYTE_BRK = 8'hF0;

   state_t           state_q, state_d;
   logic             pend_ext_q, pend_ext_d;
   logic             pend_brk_q, pend_brk_d;
   logic             wait_q, wait_d;
   logic             nextdata_n_q, nextdata_n_d;
   logic [7:0]       key_code_q, key_code_d;
   logic             key_ext_q, key_ext_d;
   logic             pressed_q, pressed_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic             capture;
   logic             same_key;

   assign capture  = i_ps2_ready && !wait_q;
   // Compared only while a key is held, so a make after release always counts.
   assign same_key = (state_q == S_HELD) &&
                     ({pend_ext_q, i_ps2_data} == {key_ext_q, key_code_q});

   always_comb begin
      state_d      = state_q;
      pend_ext_d   = pend_ext_q;
      pend_brk_d   = pend_brk_q;
      wait_d       = 1'b0;
      nextdata_n_d = 1'b1;
      key_code_d   = key_code_q;
      key_ext_d    = key_ext_q;
      pressed_d    = 1'b0;
      count_d      = count_q;

      if (capture) begin
         wait_d       = 1'b1;
         nextdata_n_d = 1'b0;
         if (i_ps2_data == BYTE_EXT) begin
            pend_ext_d = 1'b1;
         end else if (i_ps2_data == BYTE_BRK) begin
            pend_brk_d = 1'b1;
         end else begin
            pend_ext_d = 1'b0;
            pend_brk_d = 1'b0;
            if (pend_brk_q) begin
               if (same_key) begin
                  state_d = S_IDLE;
               end
            end else if (!same_key) begin
               state_d    = S_HELD;
               key_code_d = i_ps2_data;
               key_ext_d  = pend_ext_q;
               pressed_d  = 1'b1;
               if (count_q == CNT_W'(COUNT_MAX)) begin
                  count_d = '0;
               end else begin
                  count_d = count_q + CNT_W'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_clr_n) begin
         state_q      <= S_IDLE;
         pend_ext_q   <= 1'b0;
         pend_brk_q   <= 1'b0;
         wait_q       <= 1'b0;
         nextdata_n_q <= 1'b1;
         key_code_q   <= 8'h00;
         key_ext_q    <= 1'b0;
         pressed_q    <= 1'b0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         pend_ext_q   <= pend_ext_d;
         pend_brk_q   <= pend_brk_d;
         wait_q       <= wait_d;
         nextdata_n_q <= nextdata_n_d;
         key_code_q   <= key_code_d;
         key_ext_q    <= key_ext_d;
         pressed_q    <= pressed_d;
         count_q      <= count_d;
      end
   end

   assign o_nextdata_n  = nextdata_n_q;
   assign o_key_code    = key_code_q;
   assign o_key_ext     = key_ext_q;
   assign o_key_valid   = (state_q == S_HELD);
   assign o_key_pressed = pressed_q;
   assign o_press_count = count_q;

endmodule
